status_reg: RTL and testbench

//   6502 processor status register (P), directly downstream of the ALU. Captures N/V/Z/C from
//   ALU results under per-flag update strobes, executes flag instructions and PLP/RTI loads,

---
 rtl/status_reg.sv | 59 +++++
 tb/tb_status_reg.sv | 127 ++++++++++++
 2 files changed

// File: rtl/status_reg.sv
// status_reg: 6502 processor status register with ALU flag capture, flag instructions,
// PLP/RTI loads, push byte generation and the one-instruction-delayed IRQ mask.
module status_reg #(
  parameter bit D_CLR_ON_INT = 1'b0,
  parameter bit RESET_I      = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sync,
  input  logic [7:0] alu_out,
  input  logic       alu_c,
  input  logic       alu_v,
  input  logic       upd_nz,
  input  logic       upd_c,
  input  logic       upd_v,
  input  logic       bit_op,
  input  logic [7:0] data_in,
  input  logic       ld_p,
  input  logic       rti,
  input  logic [2:0] flag_op,
  input  logic       int_entry,
  input  logic       push_brk,
  output logic [7:0] p_out,
  output logic       c_out,
  output logic       d_out,
  output logic       irq_mask
);
  localparam logic [2:0] CLC = 3'd1, SEC = 3'd2, CLI = 3'd3, SEI = 3'd4,
                         CLV = 3'd5, CLD = 3'd6, SED = 3'd7;
  logic n_q, v_q, d_q, i_q, z_q, c_q, m_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d, m_d;
  always_comb begin
    c_d = ld_p ? data_in[0] : flag_op == CLC ? 1'b0 : flag_op == SEC ? 1'b1 :
          upd_c ? alu_c : c_q;
    z_d = ld_p ? data_in[1] : upd_nz ? (alu_out == 8'h00) : z_q;
    i_d = ld_p ? data_in[2] : int_entry ? 1'b1 : flag_op == CLI ? 1'b0 :
          flag_op == SEI ? 1'b1 : i_q;
    d_d = ld_p ? data_in[3] : (int_entry && D_CLR_ON_INT) ? 1'b0 :
          flag_op == CLD ? 1'b0 : flag_op == SED ? 1'b1 : d_q;
    v_d = ld_p ? data_in[6] : flag_op == CLV ? 1'b0 : bit_op ? data_in[6] :
          upd_v ? alu_v : v_q;
    n_d = ld_p ? data_in[7] : bit_op ? data_in[7] : upd_nz ? alu_out[7] : n_q;
    // Mask follows the pre-update I at instruction boundaries; interrupt entry and RTI bypass that delay.
    m_d = int_entry ? 1'b1 : (ld_p && rti) ? data_in[2] : sync ? i_q : m_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {n_q, v_q, d_q, z_q, c_q} <= '0;
      i_q <= RESET_I;
      m_q <= RESET_I;
    end else begin
      {n_q, v_q, d_q, i_q, z_q, c_q, m_q} <= {n_d, v_d, d_d, i_d, z_d, c_d, m_d};
    end
  end
  assign p_out    = {n_q, v_q, 1'b1, push_brk, d_q, i_q, z_q, c_q};
  assign c_out    = c_q;
  assign d_out    = d_q;
  assign irq_mask = m_q;
endmodule

// File: tb/tb_status_reg.sv
// tb_status_reg: directed vectors against hand-computed P values for NMOS and 65C02 variants.
module tb_status_reg;
  logic       clk = 1'b0, rst_n = 1'b1, sync, ld_p, rti, int_entry, push_brk;
  logic       alu_c, alu_v, upd_nz, upd_c, upd_v, bit_op;
  logic [7:0] alu_out, data_in;
  logic [2:0] flag_op;
  logic [7:0] p0, p1;
  logic       c0, d0, m0, c1, d1, m1;
  int         n_chk = 0, n_fail = 0;
  always #5 clk = ~clk;
  status_reg dut0 (
    .clk(clk), .rst_n(rst_n), .sync(sync), .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_op(bit_op), .data_in(data_in),
    .ld_p(ld_p), .rti(rti), .flag_op(flag_op), .int_entry(int_entry), .push_brk(push_brk),
    .p_out(p0), .c_out(c0), .d_out(d0), .irq_mask(m0)
  );
  status_reg #(.D_CLR_ON_INT(1'b1)) dut1 (
    .clk(clk), .rst_n(rst_n), .sync(sync), .alu_out(alu_out), .alu_c(alu_c), .alu_v(alu_v),
    .upd_nz(upd_nz), .upd_c(upd_c), .upd_v(upd_v), .bit_op(bit_op), .data_in(data_in),
    .ld_p(ld_p), .rti(rti), .flag_op(flag_op), .int_entry(int_entry), .push_brk(push_brk),
    .p_out(p1), .c_out(c1), .d_out(d1), .irq_mask(m1)
  );
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask
  task automatic idle();
    {sync, ld_p, rti, int_entry, push_brk, alu_c, alu_v, upd_nz, upd_c, upd_v, bit_op} = '0;
    alu_out = 8'h00;
    data_in = 8'h00;
    flag_op = 3'd0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask
  initial begin
    idle();
    #3 rst_n = 1'b0;
    #1;
    check("rst_p", p0, 8'h24);
    check("rst_mask", {7'd0, m0}, 8'h01);
    check("rst_cd", {6'd0, c0, d0}, 8'h00);
    @(negedge clk);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    sync = 1'b1; flag_op = 3'd3;
    step();
    check("cli_p", p0, 8'h20);
    check("cli_mask_held", {7'd0, m0}, 8'h01);
    sync = 1'b1;
    step();
    check("nop_mask", {7'd0, m0}, 8'h00);
    alu_out = 8'h00; alu_c = 1'b1; alu_v = 1'b1; upd_nz = 1'b1; upd_c = 1'b1; upd_v = 1'b1;
    step();
    check("alu_zero", p0, 8'h63);
    check("alu_cout", {7'd0, c0}, 8'h01);
    alu_out = 8'h80; upd_nz = 1'b1;
    step();
    check("alu_neg", p0, 8'hE1);
    flag_op = 3'd5;
    step();
    check("clv", p0, 8'hA1);
    data_in = 8'hC0; alu_out = 8'h00; bit_op = 1'b1; upd_nz = 1'b1; upd_v = 1'b1; alu_v = 1'b0;
    step();
    check("bit", p0, 8'hE3);
    flag_op = 3'd5; upd_c = 1'b1; alu_c = 1'b0;
    step();
    check("clv_upd_c", p0, 8'hA2);
    data_in = 8'h00; alu_out = 8'h55; bit_op = 1'b1;
    step();
    check("bit_keep_z", p0, 8'h22);
    sync = 1'b1; flag_op = 3'd4;
    step();
    check("sei_p", p0, 8'h26);
    check("sei_mask_held", {7'd0, m0}, 8'h00);
    sync = 1'b1;
    step();
    check("sei_mask_late", {7'd0, m0}, 8'h01);
    ld_p = 1'b1; rti = 1'b1; data_in = 8'hFB;
    step();
    check("rti_p", p0, 8'hEB);
    check("rti_mask", {7'd0, m0}, 8'h00);
    ld_p = 1'b1; data_in = 8'h04;
    step();
    check("plp_p", p0, 8'h24);
    check("plp_mask_held", {7'd0, m0}, 8'h00);
    sync = 1'b1;
    step();
    check("plp_mask_late", {7'd0, m0}, 8'h01);
    sync = 1'b1; ld_p = 1'b1; rti = 1'b1; data_in = 8'h00;
    step();
    check("rti_sync_mask", {7'd0, m0}, 8'h00);
    check("rti_sync_p", p0, 8'h20);
    flag_op = 3'd7;
    step();
    check("sed_d", {7'd0, d0}, 8'h01);
    ld_p = 1'b1; data_in = 8'h00; flag_op = 3'd2; upd_c = 1'b1; alu_c = 1'b1; int_entry = 1'b1;
    step();
    check("coll_p", p0, 8'h20);
    check("coll_mask", {7'd0, m0}, 8'h01);
    flag_op = 3'd7;
    step();
    int_entry = 1'b1; push_brk = 1'b1;
    step();
    push_brk = 1'b1;
    #1;
    check("int_nmos_p", p0, 8'h3C);
    check("int_cmos_p", p1, 8'h34);
    check("int_cmos_d", {7'd0, d1}, 8'h00);
    push_brk = 1'b0;
    flag_op = 3'd3;
    step();
    #2 rst_n = 1'b0;
    #1;
    check("rst2_p", p0, 8'h24);
    check("rst2_mask", {7'd0, m0}, 8'h01);
    rst_n = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
